// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 scan-code decoder slice.
package ps2_pkg;

  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;
  localparam logic [7:0] PFX_PAUSE = 8'hE1;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] BAT_OK    = 8'hAA;
  localparam logic [7:0] ACK       = 8'hFA;

  typedef enum logic [1:0] {
    IDLE,
    POP,
    GAP,
    DEC
  } state_t;

  // Keyboard status/response bytes that never form part of a key code.
  function automatic logic is_ctrl_byte(input logic [7:0] b);
    case (b)
      8'h00, BAT_OK, 8'hEE, ACK, 8'hFC, 8'hFD, 8'hFE, 8'hFF: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_ascii_rom.sv
// Combinational Set-2 scan code to ASCII lookup, shift selects upper case.
module ps2_ascii_rom
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       shift,
  output logic [7:0] ascii
);

  // Table lookup; letters are stored lower case and folded when shifted.
  always_comb begin
    ascii = '0;
    case (code)
      8'h1C: ascii = 8'h61; 8'h32: ascii = 8'h62; 8'h21: ascii = 8'h63;
      8'h23: ascii = 8'h64; 8'h24: ascii = 8'h65; 8'h2B: ascii = 8'h66;
      8'h34: ascii = 8'h67; 8'h33: ascii = 8'h68; 8'h43: ascii = 8'h69;
      8'h3B: ascii = 8'h6A; 8'h42: ascii = 8'h6B; 8'h4B: ascii = 8'h6C;
      8'h3A: ascii = 8'h6D; 8'h31: ascii = 8'h6E; 8'h44: ascii = 8'h6F;
      8'h4D: ascii = 8'h70; 8'h15: ascii = 8'h71; 8'h2D: ascii = 8'h72;
      8'h1B: ascii = 8'h73; 8'h2C: ascii = 8'h74; 8'h3C: ascii = 8'h75;
      8'h2A: ascii = 8'h76; 8'h1D: ascii = 8'h77; 8'h22: ascii = 8'h78;
      8'h35: ascii = 8'h79; 8'h1A: ascii = 8'h7A;
      8'h45: ascii = 8'h30; 8'h16: ascii = 8'h31; 8'h1E: ascii = 8'h32;
      8'h26: ascii = 8'h33; 8'h25: ascii = 8'h34; 8'h2E: ascii = 8'h35;
      8'h36: ascii = 8'h36; 8'h3D: ascii = 8'h37; 8'h3E: ascii = 8'h38;
      8'h46: ascii = 8'h39;
      8'h29: ascii = 8'h20;
      8'h5A: ascii = 8'h0D;
      8'h66: ascii = 8'h08;
      default: ascii = '0;
    endcase
    if (shift && ascii >= 8'h61 && ascii <= 8'h7A) ascii = ascii - 8'h20;
  end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// Pops Set-2 bytes from the PS/2 receiver FIFO, strips prefixes and emits
// one registered key event per complete scan code.
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned PAUSE_LEN = 7
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_release,
  output logic             key_repeat,
  output logic [7:0]       ascii,
  output logic             key_down,
  output logic [7:0]       held_code,
  output logic [CNT_W-1:0] press_count,
  output logic             err
);

  localparam int unsigned PW = (PAUSE_LEN > 0) ? $clog2(PAUSE_LEN + 1) : 1;

  state_t        state;
  logic [7:0]    byte_r;
  logic          ext_f;
  logic          brk_f;
  logic          shift_l;
  logic          shift_r;
  logic          held_ext;
  logic [PW-1:0] pause_cnt;
  logic [7:0]    rom_ascii;
  logic          held_match;

  ps2_ascii_rom u_rom (
    .code  (byte_r),
    .shift (shift_l | shift_r),
    .ascii (rom_ascii)
  );

  assign held_match = key_down && (byte_r == held_code) && (ext_f == held_ext);

  // Pop/settle/decode sequencer with registered event outputs and key state.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state       <= IDLE;
      nextdata_n  <= 1'b1;
      byte_r      <= '0;
      ext_f       <= 1'b0;
      brk_f       <= 1'b0;
      shift_l     <= 1'b0;
      shift_r     <= 1'b0;
      held_ext    <= 1'b0;
      pause_cnt   <= '0;
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_release <= 1'b0;
      key_repeat  <= 1'b0;
      ascii       <= '0;
      key_down    <= 1'b0;
      held_code   <= '0;
      press_count <= '0;
      err         <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      err       <= overflow;
      case (state)
        IDLE: begin
          if (ready) begin
            byte_r     <= data;
            nextdata_n <= 1'b0;
            state      <= POP;
          end
        end
        POP: begin
          nextdata_n <= 1'b1;
          state      <= GAP;
        end
        GAP: state <= DEC;
        DEC: begin
          state <= IDLE;
          if (pause_cnt != '0) begin
            pause_cnt <= pause_cnt - PW'(1);
          end else if (byte_r == PFX_PAUSE) begin
            pause_cnt <= PW'(PAUSE_LEN);
            ext_f     <= 1'b0;
            brk_f     <= 1'b0;
          end else if (byte_r == PFX_EXT) begin
            ext_f <= 1'b1;
          end else if (byte_r == PFX_BRK) begin
            brk_f <= 1'b1;
          end else if (is_ctrl_byte(byte_r)) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
          end else begin
            key_valid   <= 1'b1;
            key_code    <= byte_r;
            key_ext     <= ext_f;
            key_release <= brk_f;
            key_repeat  <= !brk_f && held_match;
            ascii       <= (ext_f || brk_f) ? 8'h00 : rom_ascii;
            ext_f       <= 1'b0;
            brk_f       <= 1'b0;
            if (!brk_f) begin
              if (!held_match) begin
                press_count <= press_count + CNT_W'(1);
                held_code   <= byte_r;
                held_ext    <= ext_f;
                key_down    <= 1'b1;
              end
            end else if (held_match) begin
              key_down <= 1'b0;
            end
            if (!ext_f && byte_r == SC_LSHIFT) shift_l <= !brk_f;
            if (!ext_f && byte_r == SC_RSHIFT) shift_r <= !brk_f;
          end
        end
        default: state <= IDLE;
      endcase
      // A fresh overflow means bytes were lost: drop any partial prefix
      // context; this overrides whatever DEC decided in the same cycle.
      if (overflow && !err) begin
        ext_f     <= 1'b0;
        brk_f     <= 1'b0;
        pause_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Scoreboard bench: receiver FIFO model feeds the decoder, a byte-level
// reference model predicts events, a monitor compares each key_valid strobe.
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       clrn;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       nextdata_n;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_release;
  logic       key_repeat;
  logic [7:0] ascii;
  logic       key_down;
  logic [7:0] held_code;
  logic [7:0] press_count;
  logic       err;

  int n_checks = 0;
  int n_errors = 0;

  ps2_scancode_decoder #(.CNT_W(8), .PAUSE_LEN(7)) dut (
    .clk         (clk),
    .clrn        (clrn),
    .data        (data),
    .ready       (ready),
    .overflow    (overflow),
    .nextdata_n  (nextdata_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ext     (key_ext),
    .key_release (key_release),
    .key_repeat  (key_repeat),
    .ascii       (ascii),
    .key_down    (key_down),
    .held_code   (held_code),
    .press_count (press_count),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       rel;
    logic       rep;
    logic [7:0] asc;
    logic       down;
    logic [7:0] held;
    logic [7:0] cnt;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] fifo[$];
  int         n_pushed = 0;
  int         n_pops   = 0;
  bit         prev_low = 1'b0;

  localparam logic [7:0] LETTERS [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  localparam logic [7:0] POOL [22] = '{
    8'h1C, 8'h32, 8'h21, 8'h12, 8'h59, 8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'hAA,
    8'hFA, 8'h45, 8'h16, 8'h29, 8'h5A, 8'h66, 8'h75, 8'h6B, 8'h00, 8'hFE,
    8'h14, 8'h1A};

  // Reference model state.
  int         m_pause;
  bit         m_ext, m_brk, m_sl, m_sr, m_down, m_hext;
  logic [7:0] m_held, m_cnt;

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit sh);
    for (int i = 0; i < 26; i++)
      if (c == LETTERS[i]) return (sh ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (c == DIGITS[i]) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    if (c == 8'h66) return 8'h08;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_pause = 0; m_ext = 0; m_brk = 0; m_sl = 0; m_sr = 0;
    m_down = 0; m_hext = 0; m_held = 8'h00; m_cnt = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    if (m_pause > 0) begin
      m_pause--;
      return;
    end
    if (b == 8'hE1) begin
      m_pause = 7; m_ext = 0; m_brk = 0;
      return;
    end
    if (b == 8'hE0) begin m_ext = 1; return; end
    if (b == 8'hF0) begin m_brk = 1; return; end
    if (b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF}) begin
      m_ext = 0; m_brk = 0;
      return;
    end
    e      = '0;
    e.code = b;
    e.ext  = m_ext;
    e.rel  = m_brk;
    e.asc  = (m_ext || m_brk) ? 8'h00 : ref_ascii(b, m_sl || m_sr);
    if (!m_brk) begin
      if (m_down && m_held == b && m_hext == m_ext) e.rep = 1;
      else begin
        m_cnt = m_cnt + 8'd1; m_held = b; m_hext = m_ext; m_down = 1;
      end
    end else if (m_held == b && m_hext == m_ext) begin
      m_down = 0;
    end
    if (!m_ext && b == 8'h12) m_sl = !m_brk;
    if (!m_ext && b == 8'h59) m_sr = !m_brk;
    e.down = m_down; e.held = m_held; e.cnt = m_cnt;
    m_ext = 0; m_brk = 0;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
    n_pushed++;
    model_byte(b);
  endtask

  task automatic drain(input string tag);
    int idle = 0;
    for (int i = 0; i < 5000 && idle < 10; i++) begin
      @(negedge clk);
      idle = (fifo.size() == 0) ? idle + 1 : 0;
    end
    n_checks++;
    if (fifo.size() != 0 || exp_q.size() != 0 || n_pops != n_pushed) begin
      n_errors++;
      $display("FAIL drain_%s fifo_left=%0d events_missing=%0d pops=%0d required_pops=%0d",
               tag, fifo.size(), exp_q.size(), n_pops, n_pushed);
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_errors++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  // Receiver FIFO: pop on a sampled low nextdata_n, then present the new head.
  always @(negedge clk) begin
    if (clrn && !nextdata_n) begin
      n_checks++;
      if (prev_low) begin
        n_errors++;
        $display("FAIL pop_width nextdata_n low for consecutive cycles got=2+ required=1");
      end
      if (fifo.size() == 0) begin
        n_errors++;
        $display("FAIL pop_empty got=pop required=no_pop");
      end else begin
        void'(fifo.pop_front());
        n_pops++;
      end
    end
    prev_low = clrn && !nextdata_n;
    ready    = (fifo.size() != 0);
    data     = ready ? fifo[0] : 8'h00;
  end

  // Monitor: every key_valid strobe consumes one predicted event.
  always @(negedge clk) begin
    ev_t got, req;
    if (clrn && key_valid) begin
      got = '{key_code, key_ext, key_release, key_repeat, ascii,
              key_down, held_code, press_count};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL event_unexpected got code=%h ext=%b rel=%b required=none",
                 got.code, got.ext, got.rel);
      end else begin
        req = exp_q.pop_front();
        if (got !== req) begin
          n_errors++;
          $display("FAIL event got code=%h ext=%b rel=%b rep=%b ascii=%h down=%b held=%h cnt=%0d required code=%h ext=%b rel=%b rep=%b ascii=%h down=%b held=%h cnt=%0d",
                   got.code, got.ext, got.rel, got.rep, got.asc, got.down, got.held, got.cnt,
                   req.code, req.ext, req.rel, req.rep, req.asc, req.down, req.held, req.cnt);
        end
      end
    end
  end

  initial begin
    clrn = 1'b0; ready = 1'b0; data = 8'h00; overflow = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_nextdata_n", 32'(nextdata_n), 32'd1);
    check("reset_flags", {key_valid, key_ext, key_release, key_repeat, key_down, err}, 32'd0);
    check("reset_bytes", {key_code, ascii, held_code, press_count}, 32'd0);
    clrn = 1'b1;
    @(negedge clk);

    // Plain make/break, then shifted letter with typematic repeat.
    push(8'h1C); push(8'hF0); push(8'h1C);
    drain("make_break");
    foreach (LETTERS[i]) if (i < 0) push(8'h00);
    push(8'h12); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
    push(8'hF0); push(8'h12); push(8'h1C);
    drain("shift");
    // Extended key: held_code must stay between make and break.
    push(8'hE0); push(8'h75);
    drain("ext_make");
    check("held_between", 32'(held_code), 32'h75);
    push(8'hE0); push(8'hF0); push(8'h75);
    drain("ext_break");
    // Pause sequence swallowed, control bytes discarded.
    push(8'hE1); push(8'h14); push(8'h77); push(8'hE1); push(8'hF0);
    push(8'h14); push(8'hF0); push(8'h77); push(8'h45);
    push(8'hAA); push(8'hFA); push(8'h29);
    drain("pause_ctrl");

    // Reset with an E0 pending must forget the prefix.
    push(8'hE0);
    drain("pre_reset");
    clrn = 1'b0;
    @(negedge clk);
    check("midreset_count", 32'(press_count), 32'd0);
    check("midreset_down", 32'(key_down), 32'd0);
    clrn = 1'b1;
    model_reset();
    push(8'h1C);
    drain("post_reset");

    // Overflow after F0 desynchronises: next 1C is a make.
    push(8'hF0);
    drain("pre_ovf");
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    m_ext = 0; m_brk = 0; m_pause = 0;
    check("err_rise", 32'(err), 32'd1);
    @(negedge clk);
    check("err_fall", 32'(err), 32'd0);
    push(8'h1C);
    drain("post_ovf");

    // press_count wrap: alternating distinct makes, no gaps.
    for (int i = 0; i < 260; i++) push((i % 2 == 0) ? 8'h32 : 8'h21);
    drain("wrap");

    // Randomised byte stream with random inter-byte gaps.
    for (int i = 0; i < 400; i++) begin
      push(POOL[$urandom_range(0, 21)]);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    drain("random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Consumer stage directly downstream of the PS/2 receiver FIFO.
- Pops raw Set-2 scan-code bytes through the receiver's data/ready/nextdata_n handshake.
- Strips E0/F0/E1 prefixes and emits one decoded key event per complete code: code, extended flag, release flag and ASCII.
- Tracks shift state, the currently held key and a make counter for the display/debug logic.

Parameters:
- CNT_W, 8, width of press_count.
- PAUSE_LEN, 7, bytes following E1 that are swallowed (the Pause sequence).

Ports:
- clk  in  1  system clock.
- clrn  in  1  asynchronous active-low reset.
- data  in  8  byte at the receiver FIFO head.
- ready  in  1  receiver FIFO non-empty.
- overflow  in  1  receiver sticky overflow flag.
- nextdata_n  out  1  active-low pop request to the receiver; exactly one cycle.
- key_valid  out  1  one-cycle strobe; the key_* outputs are valid this cycle.
- key_code  out  8  final scan-code byte, prefixes removed.
- key_ext  out  1  code was preceded by E0.
- key_release  out  1  code was preceded by F0 (break).
- key_repeat  out  1  make of a key that is already held (typematic).
- ascii  out  8  ASCII for key_code; 0 if unmapped, extended or release.
- key_down  out  1  a key is currently held.
- held_code  out  8  code of the held key.
- press_count  out  CNT_W  count of non-repeat makes; wraps.
- err  out  1  registered copy of overflow.

Behaviour:
- Reset (clrn=0, asynchronous):
  - Outputs: nextdata_n=1; key_valid, key_ext, key_release, key_repeat, key_down, err = 0; key_code, ascii, held_code, press_count = 0.
  - Internal state: FSM=IDLE, prefix flags clear, shift flags clear, pause counter 0.
  - Reset mid-sequence discards any partial prefix state.
- FSM states:
  - IDLE: if ready=1, latch data into byte_r, drive nextdata_n=0 next cycle, go to POP.
  - POP: nextdata_n=0 for exactly one cycle, go to GAP.
  - GAP: nextdata_n=1 for one cycle so the receiver's ready/data settle, go to DEC.
  - DEC: classify byte_r, update state, go to IDLE.
  - Minimum 4 cycles per byte. Back-to-back FIFO bytes are consumed without loss. ready is never sampled in POP or GAP.
- Classification in DEC, in priority order:
  1. pause_cnt != 0: decrement pause_cnt, discard byte.
  2. E1: pause_cnt <= PAUSE_LEN, clear prefixes, no event.
  3. E0: set ext_f.
  4. F0: set brk_f.
  5. 00, AA, EE, FA, FC, FD, FE, FF: discard and clear both prefix flags.
  6. Otherwise emit an event.
- Event (registered outputs, key_valid high the cycle after DEC; latency ready-high to key_valid = 4 clk):
  - key_code=byte_r, key_ext=ext_f, key_release=brk_f; then clear ext_f and brk_f.
  - Make:
    - Key equals held key (same code and ext) with key_down=1: key_repeat=1, press_count unchanged.
    - Otherwise: key_repeat=0, press_count+1 (wraps 2^CNT_W-1 to 0), held_code/held_ext <= this key, key_down=1.
  - Break: if it matches the held key, key_down=0 (held_code retained); else key_down unchanged. key_repeat=0.
- Shift tracking:
  - 12 (L) and 59 (R), non-extended: make sets the corresponding flag, break clears it.
  - Shift events are still emitted with ascii=0.
- ascii:
  - From a combinational ROM on (key_code, shift).
  - Letters 1C..1A map to 'a'..'z', or 'A'..'Z' when either shift is held.
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9'.
  - 29 maps to 20h, 5A to 0Dh, 66 to 08h.
  - Everything else is 0. Forced to 0 when key_ext=1 or key_release=1.
- Overflow:
  - err follows overflow with a 1-cycle register.
  - On the first cycle err rises, clear both prefix flags and pause_cnt (the stream is desynchronised). key_down is untouched.
- key_valid is deasserted every cycle except the event cycle. key_* outputs hold their last values otherwise.

Decomposition:
- Shared package ps2_pkg:
  - Byte constants: PFX_EXT=E0, PFX_BRK=F0, PFX_PAUSE=E1, SC_LSHIFT=12, SC_RSHIFT=59, BAT_OK=AA, ACK=FA.
  - FSM state encoding: IDLE, POP, GAP, DEC.
- One sub-module: ps2_ascii_rom (pure combinational: code, shift -> ascii).

Test Plan:
- Push 1C, F0, 1C -> two events: (code 1C, rel 0, ascii 61h, key_down 1, press_count 1), then (1C, rel 1, ascii 0, key_down 0); nextdata_n low exactly 3 single cycles.
- Push 12, 1C, 1C, F0, 1C, F0, 12 -> first 1C gives ascii 41h, count 2; second 1C gives key_repeat=1, count still 2; final key_down=0, shift cleared.
- Push E0, 75, E0, F0, 75 -> events (75, ext 1, rel 0, ascii 0), then (75, ext 1, rel 1); held_code=75 between them.
- Push E1, 14, 77, E1, F0, 14, F0, 77, then 45 -> only one event: 45, ascii 30h.
- Push AA, FA, then 29 -> single event 29, ascii 20h; no events for AA/FA.
- Push E0, pulse clrn low mid-stream, then push 1C -> event 1C with ext 0, press_count 1. Separately, assert overflow after F0 -> err=1 next cycle, the following 1C is a make (rel 0).
